// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_os
// Purpose : 8N1 UART receiver. Each bit is a 2-of-3 vote of mid-bit samples.
//           Detects framing errors and breaks. Define UART_RX_FIFO_EN to add
//           a receive FIFO.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_os #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 2_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_i,
   input  logic       ready_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       error_o,
   output logic       brk_o,
   output logic       overrun_o
);
   localparam int DIV  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int PW   = $clog2(DIV);

   if (DIV < 8) begin : g_div_check
      $error("uart_rx_os: CLK_FREQ/BAUD_RATE must be at least 8");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_rx_os: FIFO_DEPTH must be a power of 2");
   end

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            prev_q;
   logic [PW-1:0]   ph_q, ph_d;
   logic [3:0]      bit_q, bit_d;
   logic            s0_q, s0_d, s1_q, s1_d;
   logic [7:0]      shift_q, shift_d;
   logic            error_q, brk_q;
   logic            rx_s, vote, decide, good, frm_err, brk_hit;

   assign rx_s   = sync_q[1];
   assign vote   = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
   assign decide = (ph_q == PW'(HALF + 1));

   // ph_q is the cycle offset inside the current bit; it reads 0 in the falling-edge cycle.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      shift_d = shift_q;
      good    = 1'b0;
      frm_err = 1'b0;
      brk_hit = 1'b0;
      if (state_q == START || state_q == DATA || state_q == STOP) begin
         if (ph_q == PW'(DIV - 1)) begin
            ph_d  = '0;
            bit_d = bit_q + 4'd1;
         end else begin
            ph_d = ph_q + PW'(1);
         end
         if (ph_q == PW'(HALF - 1)) s0_d = rx_s;
         if (ph_q == PW'(HALF))     s1_d = rx_s;
      end
      case (state_q)
         IDLE: begin
            if (prev_q && !rx_s) begin
               state_d = START;
               ph_d    = PW'(1);
               bit_d   = 4'd0;
            end
         end
         START: begin
            if (decide) state_d = vote ? IDLE : DATA;
         end
         DATA: begin
            if (decide && bit_q != 4'd0) begin
               shift_d = {vote, shift_q[7:1]};
               if (bit_q == 4'd8) state_d = STOP;
            end
         end
         STOP: begin
            if (decide && bit_q == 4'd9) begin
               if (vote) begin
                  good    = 1'b1;
                  state_d = IDLE;
               end else begin
                  brk_hit = (shift_q == 8'h00);
                  frm_err = (shift_q != 8'h00);
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         ph_q    <= '0;
         bit_q   <= 4'd0;
         s0_q    <= 1'b1;
         s1_q    <= 1'b1;
         shift_q <= 8'h00;
         error_q <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], rx_i};
         prev_q  <= rx_s;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         shift_q <= shift_d;
         error_q <= frm_err;
         brk_q   <= brk_hit;
      end
   end

   assign error_o = error_q;
   assign brk_o   = brk_q;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          ovr_q;
   logic          avail, full, pop, push;

   assign avail = (cnt_q != '0);
   assign full  = cnt_q[AW];
   assign pop   = avail & ready_i;
   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign push  = good & (~full | pop);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
         ovr_q <= good & full & ~pop;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= shift_q;
   end

   assign data_o    = avail ? mem_q[rd_q] : 8'h00;
   assign valid_o   = avail;
   assign overrun_o = ovr_q;
`else
   logic [7:0] data_q;
   logic       valid_q;
   logic       unused_ready;

   assign unused_ready = ready_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         valid_q <= good;
         if (good) data_q <= shift_q;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_os
// Purpose : Self-checking bench for uart_rx_os: directed and random frames
//           checked against an event-list reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_os;
   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 2_000_000;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int HALF     = DIV / 2;
   // Line change after edge N -> 2 sync stages -> stop decision -> registered output.
   localparam int LAT      = 2 + 9 * DIV + HALF + 2;

   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, error, brk, overrun;

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(16)) dut (
      .clk_i    (clk),
      .reset_i  (reset_i),
      .rx_i     (rx),
      .ready_i  (ready),
      .data_o   (data),
      .valid_o  (valid),
      .error_o  (error),
      .brk_o    (brk),
      .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected output events: 1 = valid byte, 2 = framing error, 3 = break.
   typedef struct {
      int         kind;
      logic [7:0] b;
      int         at;
   } ev_t;
   ev_t        expq[$];
   logic [7:0] last_byte = 8'h00;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame; stop=0 holds the line low for extra cycles after the stop bit.
   task automatic send(input logic [7:0] b, input logic stop, input int low_extra);
      ev_t e;
      e.b    = b;
      e.at   = cyc + LAT;
      e.kind = stop ? 1 : ((b == 8'h00) ? 3 : 2);
`ifndef UART_RX_FIFO_EN
      expq.push_back(e);
`endif
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(DIV);
      end
      rx = stop;
      tick(DIV);
      if (!stop) tick(low_extra);
      rx = 1'b1;
   endtask

   task automatic glitch(input int len);
      rx = 1'b0;
      tick(len);
      rx = 1'b1;
      tick(20);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, data, 8'h00);
      check({tag, "_valid"}, valid, 1'b0);
      check({tag, "_error"}, error, 1'b0);
      check({tag, "_brk"}, brk, 1'b0);
      check({tag, "_overrun"}, overrun, 1'b0);
   endtask

`ifndef UART_RX_FIFO_EN
   always @(negedge clk) begin
      if (!reset_i && (valid || error || brk || overrun)) begin
         int  kind;
         ev_t e;
         kind = valid ? 1 : (error ? 2 : (brk ? 3 : 0));
         check("exclusive", 32'(valid) + 32'(error) + 32'(brk), 1);
         check("overrun_tied", overrun, 1'b0);
         if (expq.size() == 0) begin
            check("spurious_event", kind, 0);
         end else begin
            e = expq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
            if (e.kind == 1) begin
               check("data", data, e.b);
               last_byte = e.b;
            end else begin
               check("data_hold", data, last_byte);
            end
         end
      end
   end
`else
   int   rises[$];
   int   ovrs[$];
   logic vprev = 1'b0;
   always @(negedge clk) begin
      if (!reset_i) begin
         if (valid && !vprev) rises.push_back(cyc);
         if (overrun) ovrs.push_back(cyc);
         vprev = valid;
      end
   end
`endif

   initial begin
      #2 reset_i = 1'b1;
      tick(3);
      check_reset_outputs("reset");
      reset_i = 1'b0;
      tick(5);

`ifndef UART_RX_FIFO_EN
      send(8'hA5, 1'b1, 0);
      tick(10);
      glitch(5);
      send(8'h3C, 1'b1, 0);
      tick(7);
      send(8'h3C, 1'b0, 0);
      tick(DIV);
      send(8'h81, 1'b1, 0);
      tick(4);
      send(8'h00, 1'b0, 2 * DIV);
      tick(DIV);
      send(8'h55, 1'b1, 0);
      send(8'h00, 1'b1, 0);
      send(8'hFF, 1'b1, 0);
      send(8'h7E, 1'b1, 0);
      tick(3);

      // Abort a frame with reset while data bit 4 is on the line.
      rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         tick(DIV);
      end
      rx = 1'b1;
      tick(HALF);
      reset_i = 1'b1;
      last_byte = 8'h00;
      tick(2);
      check_reset_outputs("midframe_reset");
      rx = 1'b1;
      tick(1);
      reset_i = 1'b0;
      tick(12 * DIV);
      send(8'h12, 1'b1, 0);
      tick(2);

      ready = 1'b1;
      for (int n = 0; n < 30; n++) begin
         logic [7:0] b;
         int         r;
         b = 8'($urandom);
         r = $urandom_range(0, 9);
         if (r == 0) begin
            glitch($urandom_range(1, 10));
         end else if (r == 1) begin
            send(b, 1'b0, $urandom_range(0, 2 * DIV));
            tick($urandom_range(1, DIV));
         end else if (r == 2) begin
            send(8'h00, 1'b0, $urandom_range(0, 3 * DIV));
            tick($urandom_range(1, DIV));
         end else begin
            send(b, 1'b1, 0);
            tick($urandom_range(0, 3));
         end
         ready = 1'($urandom);
      end
      tick(LAT);
      check("pending_events", expq.size(), 0);
`else
      begin
         int st0;
         int st16;
         ready = 1'b0;
         st0  = cyc;
         st16 = cyc + 16 * (10 * DIV);
         for (int i = 0; i <= 16; i++) send(8'(i), 1'b1, 0);
         tick(5);
         check("valid_rises", rises.size(), 1);
         if (rises.size() > 0) check("first_latency", rises[0], st0 + LAT);
         check("overrun_count", ovrs.size(), 1);
         if (ovrs.size() > 0) check("overrun_cycle", ovrs[0], st16 + LAT);
         check("error_idle", error, 1'b0);
         check("brk_idle", brk, 1'b0);
         ready = 1'b1;
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("fifo_valid", valid, 1'b1);
            check("fifo_data", data, 32'(i));
         end
         @(negedge clk);
         check("fifo_empty", valid, 1'b0);
         check("fifo_empty_data", data, 8'h00);
         #1;
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
